// File: rtl/msk_pkg.sv
// -----------------------------------------------------------------------------
// msk_pkg
//   Shared definitions for the masking front end.
//   - msk_nrnd(d, w): randomness bits consumed per word, (d-1)*w.
//   - share_lo(idx, w): low bit index of share/mask idx in a packed vector.
//   - hs_t: a valid/ready handshake pair.
// -----------------------------------------------------------------------------
package msk_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    function automatic int msk_nrnd(input int d, input int w);
        return (d - 1) * w;
    endfunction

    function automatic int share_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/msk_vr_slice.sv
// -----------------------------------------------------------------------------
// msk_vr_slice
//   One valid/ready pipeline register. The slice can take a new item whenever
//   it is empty or its current item leaves in the same cycle:
//     in_ready = ~out_valid | out_ready
//   Ports:
//     clk, rst            rising-edge clock, synchronous active-high reset
//     in_valid/in_ready   upstream handshake
//     in_data [WIDTH]     upstream payload
//     out_valid/out_ready downstream handshake
//     out_data [WIDTH]    registered payload
//   RST_DATA selects whether the payload register is cleared by rst.
// -----------------------------------------------------------------------------
module msk_vr_slice #(
    parameter int WIDTH    = 8,
    parameter bit RST_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
        end
    end

    // NOTE: the payload is qualified by out_valid, so it only needs a reset
    // where the payload itself is an observable port value.
    always_ff @(posedge clk) begin
        if (RST_DATA && rst) begin
            out_data <= '0;
        end else if (in_valid && in_ready) begin
            out_data <= in_data;
        end
    end

endmodule

// File: rtl/msk_share_encoder.sv
// -----------------------------------------------------------------------------
// msk_share_encoder
//   Turns plaintext words into d-share Boolean sharings using fresh randomness.
//   Stage A captures the word and its masks; stage B registers the shares, so
//   out_shares is driven straight from flops with no unmasked glitch path.
//   Ports:
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     in_data/in_valid/in_ready plaintext word handshake
//     rnd/rnd_valid/rnd_ready  (d-1)*W fresh random bits, joined with in_*
//     out_shares/out_valid/out_ready  share i at out_shares[i*W +: W]
//     zero_rnd                 sticky all-zero-mask flag (optional)
//   Optional feature macro: MSK_ENC_ZERO_RND_DETECT_EN adds zero_rnd.
// -----------------------------------------------------------------------------
module msk_share_encoder
    import msk_pkg::*;
#(
    parameter  int d    = 2,
    parameter  int W    = 32,
    localparam int NRND = msk_nrnd(d, W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NRND-1:0]   rnd,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    output logic [d*W-1:0]    out_shares,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MSK_ENC_ZERO_RND_DETECT_EN
    ,
    output logic              zero_rnd
`endif
);

    hs_t a_hs;   // valid: stage A holds a word, ready: stage A can take one
    hs_t b_hs;   // valid: stage B holds shares, ready: stage B can take one

    logic [W+NRND-1:0] a_q;
    (* keep = "true" *) logic [W-1:0]    x_a;
    (* keep = "true" *) logic [NRND-1:0] r_a;
    logic [d*W-1:0]    b_d;
    logic [W-1:0]      last_share;
    logic              accept;

    // Word and randomness are only ever taken together; reset blocks intake.
    assign in_ready  = a_hs.ready & ~rst;
    assign rnd_ready = in_ready;
    assign accept    = in_valid & rnd_valid & in_ready;

    msk_vr_slice #(
        .WIDTH    (W + NRND),
        .RST_DATA (1'b0)
    ) u_stage_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & rnd_valid & ~rst),
        .in_ready  (a_hs.ready),
        .in_data   ({rnd, in_data}),
        .out_valid (a_hs.valid),
        .out_ready (b_hs.ready),
        .out_data  (a_q)
    );

    assign x_a = a_q[W-1:0];
    assign r_a = a_q[W+NRND-1:W];

    // Recombination lives only here, feeding stage B's D input.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        b_d        = '0;
        last_share = x_a;
        for (int k = 0; k < d - 1; k++) begin
            b_d[share_lo(k, W) +: W] = r_a[share_lo(k, W) +: W];
            last_share               = last_share ^ r_a[share_lo(k, W) +: W];
        end
        b_d[share_lo(d - 1, W) +: W] = last_share;
    end

    msk_vr_slice #(
        .WIDTH    (d * W),
        .RST_DATA (1'b1)
    ) u_stage_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_hs.valid),
        .in_ready  (b_hs.ready),
        .in_data   (b_d),
        .out_valid (b_hs.valid),
        .out_ready (out_ready),
        .out_data  (out_shares)
    );

    assign out_valid = b_hs.valid;

`ifdef MSK_ENC_ZERO_RND_DETECT_EN
    logic rnd_has_zero;

    always_comb begin
        rnd_has_zero = 1'b0;
        for (int k = 0; k < d - 1; k++) begin
            if (rnd[share_lo(k, W) +: W] == '0) begin
                rnd_has_zero = 1'b1;
            end
        end
    end

    // Health flag: sticky until reset; the word is still encoded normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_rnd <= 1'b0;
        end else if (accept && rnd_has_zero) begin
            zero_rnd <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_msk_share_encoder.sv
// -----------------------------------------------------------------------------
// tb_msk_share_encoder
//   Two encoder instances: d=2/W=32 (main, scoreboarded) and d=3/W=8.
//   Inputs change on the falling edge; outputs are read 1 time unit later.
// -----------------------------------------------------------------------------
module tb_msk_share_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // d=2, W=32 instance
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rnd;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [63:0] out_shares;
    logic        out_valid;
    logic        out_ready;

    // d=3, W=8 instance
    logic [7:0]  in_data3;
    logic        in_valid3;
    logic        in_ready3;
    logic [15:0] rnd3;
    logic        rnd_valid3;
    logic        rnd_ready3;
    logic [23:0] out_shares3;
    logic        out_valid3;
    logic        out_ready3;

`ifdef MSK_ENC_ZERO_RND_DETECT_EN
    logic        zero_rnd;
    logic        zero_rnd3;
`endif

    msk_share_encoder #(.d(2), .W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rnd        (rnd),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .out_shares (out_shares),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef MSK_ENC_ZERO_RND_DETECT_EN
        ,
        .zero_rnd   (zero_rnd)
`endif
    );

    msk_share_encoder #(.d(3), .W(8)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data3),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .rnd        (rnd3),
        .rnd_valid  (rnd_valid3),
        .rnd_ready  (rnd_ready3),
        .out_shares (out_shares3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3)
`ifdef MSK_ENC_ZERO_RND_DETECT_EN
        ,
        .zero_rnd   (zero_rnd3)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: words in flight, each with the step it was accepted.
    typedef struct {
        logic [31:0] x;
        logic [31:0] r;
        int          t;
    } word_t;

    word_t       q[$];
    int          step = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_shares = '0;

    // One cycle on the main instance, checked against the model:
    //   - two words may be in flight; beyond that intake waits for out_ready
    //   - a word is visible at the output two edges after acceptance
    //   - share0 is the mask, share0^share1 is the plaintext, order preserved
    task automatic sb_step(input logic [31:0] x, input logic xv,
                           input logic [31:0] r, input logic rv,
                           input logic ordy);
        logic  exp_ready;
        logic  exp_ov;
        word_t w;
        @(negedge clk);
        in_data   = x;
        in_valid  = xv;
        rnd       = r;
        rnd_valid = rv;
        out_ready = ordy;
        #1;
        exp_ready = (q.size() < 2) || ordy;
        exp_ov    = (q.size() > 0) && (step - q[0].t >= 2);
        total++;
        if (in_ready !== exp_ready) begin
            bad++;
            $display("FAIL in_ready step=%0d got=%b exp=%b", step, in_ready, exp_ready);
        end
        total++;
        if (rnd_ready !== exp_ready) begin
            bad++;
            $display("FAIL rnd_ready step=%0d got=%b exp=%b", step, rnd_ready, exp_ready);
        end
        total++;
        if (out_valid !== exp_ov) begin
            bad++;
            $display("FAIL out_valid step=%0d got=%b exp=%b", step, out_valid, exp_ov);
        end
        if (prev_stall) begin
            total++;
            if (out_shares !== prev_shares) begin
                bad++;
                $display("FAIL stall_hold step=%0d got=%h exp=%h", step, out_shares, prev_shares);
            end
        end
        if (exp_ov && ordy) begin
            w = q.pop_front();
            total++;
            if (out_shares[31:0] !== w.r) begin
                bad++;
                $display("FAIL share0 step=%0d got=%h exp=%h", step, out_shares[31:0], w.r);
            end
            total++;
            if ((out_shares[63:32] ^ out_shares[31:0]) !== w.x) begin
                bad++;
                $display("FAIL share_xor step=%0d got=%h exp=%h", step,
                         out_shares[63:32] ^ out_shares[31:0], w.x);
            end
        end
        if (xv && rv && exp_ready) begin
            w.x = x;
            w.r = r;
            w.t = step;
            q.push_back(w);
        end
        prev_stall  = exp_ov && !ordy;
        prev_shares = out_shares;
        step++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sb_step(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; rnd = '0; rnd_valid = 1'b0; out_ready = 1'b1;
        in_data3 = '0; in_valid3 = 1'b0; rnd3 = '0; rnd_valid3 = 1'b0; out_ready3 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || rnd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b%b exp=00", in_ready, rnd_ready);
        end
        total++;
        if (out_valid !== 1'b0 || out_shares !== 64'h0) begin
            bad++;
            $display("FAIL reset_out got=%b/%h exp=0/0", out_valid, out_shares);
        end
        total++;
        if (out_valid3 !== 1'b0 || out_shares3 !== 24'h0) begin
            bad++;
            $display("FAIL reset_out3 got=%b/%h exp=0/0", out_valid3, out_shares3);
        end
`ifdef MSK_ENC_ZERO_RND_DETECT_EN
        total++;
        if (zero_rnd !== 1'b0 || zero_rnd3 !== 1'b0) begin
            bad++;
            $display("FAIL reset_zero_rnd got=%b%b exp=00", zero_rnd, zero_rnd3);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready got=%b%b exp=11", in_ready, in_ready3);
        end
    endtask

    task automatic test_known_vector();
        sb_step(32'hDEADBEEF, 1'b1, 32'h12345678, 1'b1, 1'b1);
        idle(2);
        total++;
        if (out_valid !== 1'b1 || out_shares !== 64'hCC99E897_12345678) begin
            bad++;
            $display("FAIL known_vector got=%b/%h exp=1/cc99e89712345678", out_valid, out_shares);
        end
        idle(1);
    endtask

    task automatic test_d3();
        @(negedge clk);
        in_data3 = 8'hA5; rnd3 = 16'hF00F; in_valid3 = 1'b1; rnd_valid3 = 1'b1; out_ready3 = 1'b1;
        #1;
        total++;
        if (in_ready3 !== 1'b1) begin
            bad++;
            $display("FAIL d3_ready got=%b exp=1", in_ready3);
        end
        @(negedge clk);
        in_valid3 = 1'b0; rnd_valid3 = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (out_valid3 !== 1'b1 || out_shares3 !== 24'h5AF00F) begin
            bad++;
            $display("FAIL d3_shares got=%b/%h exp=1/5af00f", out_valid3, out_shares3);
        end
        total++;
        if ((out_shares3[7:0] ^ out_shares3[15:8] ^ out_shares3[23:16]) !== 8'hA5) begin
            bad++;
            $display("FAIL d3_xor got=%h exp=a5",
                     out_shares3[7:0] ^ out_shares3[15:8] ^ out_shares3[23:16]);
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid3 !== 1'b0) begin
            bad++;
            $display("FAIL d3_single got=%b exp=0", out_valid3);
        end
    endtask

    task automatic test_stall();
        sb_step(32'h1111_0001, 1'b1, 32'hA0A0_0001, 1'b1, 1'b0);
        sb_step(32'h2222_0002, 1'b1, 32'hB0B0_0002, 1'b1, 1'b0);
        sb_step(32'h3333_0003, 1'b1, 32'hC0C0_0003, 1'b1, 1'b0);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_full got=%b exp=0", in_ready);
        end
        for (int i = 0; i < 3; i++) sb_step(32'h3333_0003, 1'b1, 32'hC0C0_0003, 1'b1, 1'b0);
        sb_step(32'h3333_0003, 1'b1, 32'hC0C0_0003, 1'b1, 1'b1);
        idle(4);
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 5; i++) sb_step(32'h5555_AAAA, 1'b1, 32'h0F0F_F0F0, 1'b0, 1'b1);
        sb_step(32'h5555_AAAA, 1'b1, 32'h0F0F_F0F0, 1'b1, 1'b1);
        idle(4);
    endtask

`ifdef MSK_ENC_ZERO_RND_DETECT_EN
    task automatic test_zero_rnd();
        @(negedge clk);
        in_data3 = 8'h11; rnd3 = 16'h003C; in_valid3 = 1'b1; rnd_valid3 = 1'b1; out_ready3 = 1'b1;
        #1;
        total++;
        if (zero_rnd3 !== 1'b0) begin
            bad++;
            $display("FAIL zero_rnd_before got=%b exp=0", zero_rnd3);
        end
        @(negedge clk);
        in_valid3 = 1'b0; rnd_valid3 = 1'b0;
        #1;
        total++;
        if (zero_rnd3 !== 1'b1) begin
            bad++;
            $display("FAIL zero_rnd_set got=%b exp=1", zero_rnd3);
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid3 !== 1'b1 || out_shares3 !== 24'h2D003C) begin
            bad++;
            $display("FAIL zero_rnd_word got=%b/%h exp=1/2d003c", out_valid3, out_shares3);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (zero_rnd3 !== 1'b1) begin
            bad++;
            $display("FAIL zero_rnd_sticky got=%b exp=1", zero_rnd3);
        end
    endtask
`endif

    task automatic test_reset_midflight();
        sb_step(32'h7777_0001, 1'b1, 32'h9999_0001, 1'b1, 1'b0);
        sb_step(32'h7777_0002, 1'b1, 32'h9999_0002, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0 || rnd_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ready got=%b%b exp=00", in_ready, rnd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_shares !== 64'h0) begin
            bad++;
            $display("FAIL mid_reset_out got=%b/%h exp=0/0", out_valid, out_shares);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready_after got=%b exp=1", in_ready);
        end
`ifdef MSK_ENC_ZERO_RND_DETECT_EN
        total++;
        if (zero_rnd3 !== 1'b0) begin
            bad++;
            $display("FAIL zero_rnd_clear got=%b exp=0", zero_rnd3);
        end
`endif
        q.delete();
        prev_stall = 1'b0;
        idle(4);
    endtask

    task automatic test_random_regression();
        int          acc_n = 0;
        int          guard = 0;
        logic [31:0] cx;
        logic [31:0] cr;
        logic        xv;
        logic        rv;
        logic        ordy;
        logic        will_acc;
        cx = $urandom;
        cr = $urandom;
        while (acc_n < 10000 && guard < 60000) begin
            xv       = ($urandom_range(0, 3) != 0);
            rv       = ($urandom_range(0, 3) != 0);
            ordy     = ($urandom_range(0, 3) != 0);
            will_acc = xv && rv && ((q.size() < 2) || ordy);
            sb_step(cx, xv, cr, rv, ordy);
            if (will_acc) begin
                acc_n++;
                cx = $urandom;
                cr = $urandom;
            end
            guard++;
        end
        total++;
        if (acc_n != 10000) begin
            bad++;
            $display("FAIL regression_budget accepted=%0d want=10000", acc_n);
        end
        idle(6);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL regression_drain left=%0d want=0", q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_vector();
        test_d3();
        test_stall();
        test_starvation();
`ifdef MSK_ENC_ZERO_RND_DETECT_EN
        test_zero_rnd();
`endif
        test_reset_midflight();
        test_random_regression();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
